// File: rtl/tiny16_pkg.sv
// Shared encodings for the tiny16 control path: opcodes, write-data sources,
// sequencer states and the decoded-instruction record.
package tiny16_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_LDI = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_LD  = 4'h5;
  localparam logic [3:0] OP_ST  = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] INSEL_ALU = 2'd0;
  localparam logic [1:0] INSEL_IMM = 2'd1;
  localparam logic [1:0] INSEL_MEM = 2'd2;
  localparam logic [1:0] INSEL_SRC = 2'd3;

  localparam logic [2:0] FETCH_A = 3'd0;
  localparam logic [2:0] FETCH_B = 3'd1;
  localparam logic [2:0] DECODE  = 3'd2;
  localparam logic [2:0] READ    = 3'd3;
  localparam logic [2:0] EXEC    = 3'd4;
  localparam logic [2:0] MEM     = 3'd5;
  localparam logic [2:0] HALT    = 3'd6;
  localparam logic [2:0] FAULT   = 3'd7;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_WR,
    CLS_LD,
    CLS_ST,
    CLS_JMP,
    CLS_HLT,
    CLS_ILL
  } op_class_e;

  typedef struct packed {
    op_class_e   cls;
    logic        legal;
    logic [1:0]  in_sel;
    logic        alu_op;
    logic [2:0]  dst;
    logic [2:0]  src;
    logic [15:0] imm;
  } decode_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Memory and register-file control bundle between the sequencer (master)
// and the datapath/memory side (slave).
interface control_sequencer_if;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [2:0]  src_sel;
  logic [2:0]  dst_sel;
  logic        in_en;
  logic        out_en;
  logic        pc_inc;
  logic [1:0]  in_sel;
  logic        alu_op;
  logic [15:0] imm;
  logic        mem_rd;
  logic        mem_wr;
  logic        addr_sel;
  logic        halted;
  logic        fault;

  modport master (
    input  mem_rdata, mem_ready,
    output src_sel, dst_sel, in_en, out_en, pc_inc, in_sel, alu_op, imm,
           mem_rd, mem_wr, addr_sel, halted, fault
  );

  modport slave (
    output mem_rdata, mem_ready,
    input  src_sel, dst_sel, in_en, out_en, pc_inc, in_sel, alu_op, imm,
           mem_rd, mem_wr, addr_sel, halted, fault
  );
endinterface

// File: rtl/control_sequencer_instr_decode.sv
// Combinational instruction decode: IR to op class, legality, register
// selects, write-data source and immediate.
module instr_decode
  import tiny16_pkg::*;
(
  input  logic [15:0] i_ir,
  output decode_t     o_dec
);

  always_comb begin
    o_dec        = '0;
    o_dec.cls    = CLS_NOP;
    o_dec.legal  = 1'b1;
    o_dec.dst    = i_ir[11:9];
    o_dec.src    = i_ir[8:6];
    o_dec.imm    = {8'h00, i_ir[7:0]};
    o_dec.in_sel = INSEL_ALU;
    o_dec.alu_op = 1'b0;
    case (i_ir[15:12])
      OP_NOP: o_dec.cls = CLS_NOP;
      OP_MOV: begin o_dec.cls = CLS_WR;  o_dec.in_sel = INSEL_SRC; end
      OP_LDI: begin o_dec.cls = CLS_WR;  o_dec.in_sel = INSEL_IMM; end
      OP_ADD: begin o_dec.cls = CLS_WR;  o_dec.in_sel = INSEL_ALU; end
      OP_SUB: begin o_dec.cls = CLS_WR;  o_dec.in_sel = INSEL_ALU; o_dec.alu_op = 1'b1; end
      OP_LD:  o_dec.cls = CLS_LD;
      OP_ST:  o_dec.cls = CLS_ST;
      OP_JMP: begin o_dec.cls = CLS_JMP; o_dec.in_sel = INSEL_SRC; end
      OP_HLT: o_dec.cls = CLS_HLT;
      default: begin o_dec.cls = CLS_ILL; o_dec.legal = 1'b0; end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// tiny16 control sequencer: fetch/decode/execute FSM driving register-file
// selects, write strobes and memory handshakes; strobes are flop outputs.
module control_sequencer
  import tiny16_pkg::*;
#(
  parameter logic [2:0] RESET_STATE = FETCH_A
) (
  input  logic                clk,
  input  logic                rst,
  control_sequencer_if.master bus
);

  logic [2:0]  r_state, w_state;
  logic [15:0] r_ir;
  logic        r_in_en, r_pc_inc, r_mem_rd, r_mem_wr, r_alu_op;
  logic [1:0]  r_in_sel;
  logic        w_in_en, w_pc_inc, w_mem_rd, w_mem_wr, w_alu_op, w_ir_load;
  logic [1:0]  w_in_sel;
  logic [2:0]  w_src_sel, w_dst_sel;
  decode_t     w_dec;

  instr_decode u_decode (
    .i_ir  (r_ir),
    .o_dec (w_dec)
  );

  // Strobes are computed for the next cycle, so anything triggered by
  // mem_ready appears in the cycle after the ready is seen.
  always_comb begin
    w_state   = r_state;
    w_in_en   = 1'b0;
    w_pc_inc  = 1'b0;
    w_mem_rd  = 1'b0;
    w_mem_wr  = 1'b0;
    w_alu_op  = 1'b0;
    w_in_sel  = INSEL_ALU;
    w_ir_load = 1'b0;
    case (r_state)
      FETCH_A: begin
        w_state  = FETCH_B;
        w_mem_rd = 1'b1;
      end
      FETCH_B: begin
        if (bus.mem_ready) begin
          w_ir_load = 1'b1;
          w_pc_inc  = 1'b1;
          w_state   = DECODE;
        end else begin
          w_mem_rd = 1'b1;
        end
      end
      DECODE: w_state = READ;
      READ: begin
        w_state = EXEC;
        if (w_dec.cls == CLS_WR || w_dec.cls == CLS_JMP) begin
          w_in_en  = 1'b1;
          w_in_sel = w_dec.in_sel;
          w_alu_op = w_dec.alu_op;
        end
      end
      EXEC: begin
        if (!w_dec.legal) begin
          w_state = FAULT;
        end else begin
          case (w_dec.cls)
            CLS_LD:  begin w_state = MEM; w_mem_rd = 1'b1; end
            CLS_ST:  begin w_state = MEM; w_mem_wr = 1'b1; end
            CLS_HLT: w_state = HALT;
            default: w_state = FETCH_A;
          endcase
        end
      end
      MEM: begin
        if (w_dec.cls == CLS_LD) begin
          if (bus.mem_ready) begin
            w_in_en  = 1'b1;
            w_in_sel = INSEL_MEM;
            w_state  = FETCH_A;
          end else begin
            w_mem_rd = 1'b1;
          end
        end else begin
          if (bus.mem_ready) w_state = FETCH_A;
          else               w_mem_wr = 1'b1;
        end
      end
      default: w_state = r_state;
    endcase
  end

  // Selects follow IR from decode onward; fetch reads r0, JMP writes r0.
  always_comb begin
    w_src_sel = w_dec.src;
    w_dst_sel = w_dec.dst;
    case (r_state)
      FETCH_A, FETCH_B: w_src_sel = '0;
      HALT, FAULT: begin
        w_src_sel = '0;
        w_dst_sel = '0;
      end
      EXEC: if (w_dec.cls == CLS_JMP) w_dst_sel = '0;
      default: w_src_sel = w_dec.src;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= RESET_STATE;
      r_ir     <= '0;
      r_in_en  <= 1'b0;
      r_pc_inc <= 1'b0;
      r_mem_rd <= 1'b0;
      r_mem_wr <= 1'b0;
      r_alu_op <= 1'b0;
      r_in_sel <= '0;
    end else begin
      r_state  <= w_state;
      if (w_ir_load) r_ir <= bus.mem_rdata;
      r_in_en  <= w_in_en;
      r_pc_inc <= w_pc_inc;
      r_mem_rd <= w_mem_rd;
      r_mem_wr <= w_mem_wr;
      r_alu_op <= w_alu_op;
      r_in_sel <= w_in_sel;
    end
  end

  assign bus.src_sel  = w_src_sel;
  assign bus.dst_sel  = w_dst_sel;
  assign bus.in_en    = r_in_en;
  assign bus.pc_inc   = r_pc_inc;
  assign bus.in_sel   = r_in_sel;
  assign bus.alu_op   = r_alu_op;
  assign bus.imm      = w_dec.imm;
  assign bus.mem_rd   = r_mem_rd;
  assign bus.mem_wr   = r_mem_wr;
  assign bus.out_en   = r_mem_wr;
  assign bus.addr_sel = r_mem_wr;
  assign bus.halted   = (r_state == HALT);
  assign bus.fault    = (r_state == FAULT);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a per-instruction timeline
// model builds expected outputs cycle by cycle from the instruction rules.
module tb_control_sequencer;
  import tiny16_pkg::*;

  typedef struct packed {
    logic [2:0]  src;
    logic [2:0]  dst;
    logic        in_en;
    logic        out_en;
    logic        pc_inc;
    logic [1:0]  in_sel;
    logic        alu_op;
    logic [15:0] imm;
    logic        mem_rd;
    logic        mem_wr;
    logic        addr_sel;
    logic        halted;
    logic        fault;
  } outs_t;

  typedef struct packed {
    logic        rdy;
    logic [15:0] rdata;
    outs_t       exp;
  } cyc_t;

  logic clk;
  logic rst;
  control_sequencer_if bus ();

  control_sequencer #(.RESET_STATE(FETCH_A)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  cyc_t        q[$];
  outs_t       act[$];
  logic [15:0] m_ir;
  bit          m_wb, m_stop, m_halt;

  function automatic outs_t get_act();
    outs_t a;
    a.src      = bus.src_sel;
    a.dst      = bus.dst_sel;
    a.in_en    = bus.in_en;
    a.out_en   = bus.out_en;
    a.pc_inc   = bus.pc_inc;
    a.in_sel   = bus.in_sel;
    a.alu_op   = bus.alu_op;
    a.imm      = bus.imm;
    a.mem_rd   = bus.mem_rd;
    a.mem_wr   = bus.mem_wr;
    a.addr_sel = bus.addr_sel;
    a.halted   = bus.halted;
    a.fault    = bus.fault;
    return a;
  endfunction

  // Selects and immediate come from the instruction held; strobes quiet.
  function automatic outs_t base_o(input logic [15:0] ir);
    outs_t o = '0;
    o.src = ir[8:6];
    o.dst = ir[11:9];
    o.imm = {8'h00, ir[7:0]};
    return o;
  endfunction

  task automatic push(input logic rdy, input logic [15:0] rd, input outs_t o);
    cyc_t c;
    c.rdy   = rdy;
    c.rdata = rd;
    c.exp   = o;
    q.push_back(c);
  endtask

  task automatic push_any(input outs_t o);
    push(1'($urandom), 16'($urandom), o);
  endtask

  task automatic start_seg();
    q.delete();
    act.delete();
    m_ir   = '0;
    m_wb   = 1'b0;
    m_stop = 1'b0;
    m_halt = 1'b0;
  endtask

  task automatic gen_fetch_a();
    outs_t o = base_o(m_ir);
    o.src = '0;
    if (m_wb) begin
      o.in_en  = 1'b1;
      o.in_sel = 2'd2;
      m_wb     = 1'b0;
    end
    push_any(o);
  endtask

  task automatic gen_instr(input logic [15:0] instr, input int wf, input int wm);
    outs_t o;
    logic [3:0] op;
    if (m_stop) return;
    gen_fetch_a();
    o = base_o(m_ir); o.src = '0; o.mem_rd = 1'b1;
    for (int i = 0; i < wf; i++) push(1'b0, 16'($urandom), o);
    push(1'b1, instr, o);
    m_ir = instr;
    o = base_o(m_ir); o.pc_inc = 1'b1;
    push_any(o);
    push_any(base_o(m_ir));
    op = instr[15:12];
    o = base_o(m_ir);
    case (op)
      4'h1: begin o.in_en = 1'b1; o.in_sel = 2'd3; end
      4'h2: begin o.in_en = 1'b1; o.in_sel = 2'd1; end
      4'h3: begin o.in_en = 1'b1; o.in_sel = 2'd0; end
      4'h4: begin o.in_en = 1'b1; o.in_sel = 2'd0; o.alu_op = 1'b1; end
      4'h7: begin o.in_en = 1'b1; o.in_sel = 2'd3; o.dst = 3'd0; end
      default: ;
    endcase
    push_any(o);
    if (op == 4'h5 || op == 4'h6) begin
      o = base_o(m_ir);
      if (op == 4'h5) o.mem_rd = 1'b1;
      else begin o.mem_wr = 1'b1; o.out_en = 1'b1; o.addr_sel = 1'b1; end
      for (int i = 0; i < wm; i++) push(1'b0, 16'($urandom), o);
      push(1'b1, 16'($urandom), o);
      if (op == 4'h5) m_wb = 1'b1;
    end else if (op == 4'hF) begin
      m_stop = 1'b1; m_halt = 1'b1;
    end else if (op > 4'h7) begin
      m_stop = 1'b1; m_halt = 1'b0;
    end
  endtask

  task automatic gen_tail(input int n);
    outs_t o;
    if (m_stop) begin
      o = '0;
      o.imm    = {8'h00, m_ir[7:0]};
      o.halted = m_halt;
      o.fault  = !m_halt;
      for (int i = 0; i < n; i++) push_any(o);
    end else begin
      gen_fetch_a();
      o = base_o(m_ir); o.src = '0; o.mem_rd = 1'b1;
      for (int i = 0; i < n; i++) push(1'b0, 16'($urandom), o);
    end
  endtask

  // Called at negedge+1 with rst low; ends the same way after an async reset.
  task automatic run_q();
    outs_t a;
    rst = 1'b1;
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      a = get_act();
      act.push_back(a);
      bus.mem_ready = q[i].rdy;
      bus.mem_rdata = q[i].rdata;
      n_vec++;
      if (a !== q[i].exp) begin
        n_err++;
        $display("FAIL cycle %0d: got %h want %h", i, a, q[i].exp);
      end
    end
    #1 rst = 1'b0;
    #1 a = get_act();
    n_vec++;
    if (a !== outs_t'(0)) begin
      n_err++;
      $display("FAIL async_reset: got %h want 0", a);
    end
    @(negedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // which: 0 in_en, 1 mem_wr, 2 out_en, 3 addr_sel, 4 any strobe
  function automatic int cnt(input int from, input int which);
    int c = 0;
    for (int i = from; i < act.size(); i++) begin
      case (which)
        0: c += int'(act[i].in_en);
        1: c += int'(act[i].mem_wr);
        2: c += int'(act[i].out_en);
        3: c += int'(act[i].addr_sel);
        default: c += int'(act[i].in_en | act[i].pc_inc | act[i].mem_rd |
                           act[i].mem_wr | act[i].out_en);
      endcase
    end
    return c;
  endfunction

  int r, n;
  logic [3:0] op;

  initial begin
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", 32'(get_act()), 32'd0);

    // LDI r5, 0x55 with memory always ready
    start_seg(); gen_instr(16'h2A55, 0, 0); gen_tail(3);
    chk("ldi_model_in_en", 32'(q[4].exp.in_en), 32'd1);
    run_q();
    chk("ldi_first_cycle", 32'(act[0]), 32'd0);
    chk("ldi_in_en", 32'(act[4].in_en), 32'd1);
    chk("ldi_dst", 32'(act[4].dst), 32'd5);
    chk("ldi_in_sel", 32'(act[4].in_sel), 32'd1);
    chk("ldi_imm", 32'(act[4].imm), 32'h55);
    chk("ldi_in_en_count", 32'(cnt(0, 0)), 32'd1);

    // ADD r3, r2
    start_seg(); gen_instr(16'h3680, 0, 0); gen_tail(3); run_q();
    chk("add_dst", 32'(act[4].dst), 32'd3);
    chk("add_src", 32'(act[4].src), 32'd2);
    chk("add_alu_op", 32'(act[4].alu_op), 32'd0);
    chk("add_in_en_count", 32'(cnt(0, 0)), 32'd1);

    // ST with three not-ready cycles
    start_seg(); gen_instr(16'h6440, 0, 3); gen_tail(3); run_q();
    chk("st_mem_wr_cycles", 32'(cnt(0, 1)), 32'd4);
    chk("st_out_en_cycles", 32'(cnt(0, 2)), 32'd4);
    chk("st_addr_sel_cycles", 32'(cnt(0, 3)), 32'd4);
    chk("st_mem_wr_last", 32'(act[8].mem_wr), 32'd1);
    chk("st_mem_wr_dropped", 32'(act[9].mem_wr), 32'd0);
    chk("st_no_in_en", 32'(cnt(0, 0)), 32'd0);

    // JMP through r2
    start_seg(); gen_instr(16'h7080, 0, 0); gen_tail(3); run_q();
    chk("jmp_pc_inc_decode", 32'(act[2].pc_inc), 32'd1);
    chk("jmp_in_en", 32'(act[4].in_en), 32'd1);
    chk("jmp_dst", 32'(act[4].dst), 32'd0);
    chk("jmp_in_sel", 32'(act[4].in_sel), 32'd3);
    chk("jmp_no_pc_inc", 32'(act[4].pc_inc), 32'd0);
    chk("jmp_fetch_src", 32'(act[5].src), 32'd0);

    // Illegal op, then HLT
    start_seg(); gen_instr(16'h8000, 0, 0); gen_tail(6); run_q();
    chk("ill_fault", 32'(act[5].fault), 32'd1);
    chk("ill_fault_held", 32'(act[10].fault), 32'd1);
    chk("ill_no_strobes", 32'(cnt(5, 4)), 32'd0);

    start_seg(); gen_instr(16'hF000, 1, 0); gen_tail(6); run_q();
    chk("hlt_halted", 32'(act[6].halted), 32'd1);
    chk("hlt_no_strobes", 32'(cnt(6, 4)), 32'd0);

    // Random programs with random memory wait states
    for (int s = 0; s < 24; s++) begin
      start_seg();
      n = $urandom_range(3, 12);
      for (int k = 0; k < n; k++) begin
        r = $urandom_range(0, 99);
        if (r < 90)      op = 4'($urandom_range(0, 7));
        else if (r < 95) op = 4'hF;
        else             op = 4'($urandom_range(8, 14));
        gen_instr({op, 12'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 3));
      end
      gen_tail(4);
      run_q();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have port mem_rdata, input, 16 bits: memory read data (instruction or operand).
REQ-004 SHALL have port mem_ready, input, 1 bit: memory access complete this cycle.
REQ-005 SHALL have ports src_sel and dst_sel, output, 3 bits each: register-file read/write selects.
REQ-006 SHALL have ports in_en, out_en and pc_inc, output, 1 bit each: register-file write, bus drive and PC (r0) increment strobes.
REQ-007 SHALL have port in_sel, output, 2 bits: write-data source. 0 = ALU, 1 = IMM, 2 = MEM, 3 = SRC.
REQ-008 SHALL have port alu_op, output, 1 bit: 0 = add, 1 = sub.
REQ-009 SHALL have port imm, output, 16 bits: {8'h00, IR[7:0]}.
REQ-010 SHALL have ports mem_rd, mem_wr and addr_sel, output, 1 bit each. addr_sel 0 = address from register-file src, 1 = from dst.
REQ-011 SHALL have ports halted and fault, output, 1 bit each: status flags.
REQ-012 SHALL use parameter RESET_STATE, default FETCH_A: state entered on reset.

Function
REQ-013 SHALL decode IR as follows: op = IR[15:12], dst = IR[11:9], src = IR[8:6].
REQ-014 SHALL support these ops: 0 NOP, 1 MOV, 2 LDI, 3 ADD, 4 SUB, 5 LD, 6 ST, 7 JMP, F HLT. Every other op is illegal.
REQ-015 SHALL implement states FETCH_A, FETCH_B, DECODE, READ, EXEC, MEM, HALT, FAULT.
REQ-016 FETCH_A SHALL drive src_sel = 0, then go to FETCH_B; this accounts for the one-cycle register-file read latency.
REQ-017 FETCH_B SHALL assert mem_rd with addr_sel = 0 until mem_ready. On mem_ready it SHALL load IR from mem_rdata, pulse pc_inc for exactly one cycle, and go to DECODE.
REQ-018 DECODE SHALL drive src_sel and dst_sel from IR, then go to READ; READ is a single wait cycle, then EXEC.
REQ-019 The selects SHALL stay stable from DECODE until the instruction retires.
REQ-020 EXEC SHALL act per op:
- MOV: in_en, in_sel = 3.
- LDI: in_en, in_sel = 1.
- ADD/SUB: in_en, in_sel = 0, alu_op = 0/1.
- NOP: nothing.
In all four cases it SHALL then go to FETCH_A.
REQ-021 EXEC for LD, ST and JMP SHALL behave as follows:
- LD and ST go to MEM.
- JMP: in_en, in_sel = 3, dst_sel forced to 0, then FETCH_A.
- HLT goes to HALT.
- Illegal ops go to FAULT.
REQ-022 MEM for LD SHALL hold mem_rd with addr_sel = 0 until mem_ready; in that cycle in_en is asserted with in_sel = 2, then FETCH_A.
REQ-023 MEM for ST SHALL hold mem_wr, out_en and addr_sel = 1 until mem_ready, then FETCH_A.
REQ-024 in_en, pc_inc, mem_rd and mem_wr SHALL be registered outputs, each single-cycle except where held awaiting mem_ready.
REQ-025 pc_inc and in_en with dst_sel = 0 SHALL never be asserted in the same cycle.
REQ-026 mem_rd and mem_wr SHALL never be asserted together.
REQ-027 out_en SHALL be asserted only during ST in MEM.
REQ-028 With mem_ready held low, the block SHALL wait indefinitely with all outputs stable.
REQ-029 HALT and FAULT SHALL be absorbing states (exit only by reset); halted and fault are 1 respectively, and all strobes are 0.

Reset
REQ-030 While rst = 0, the state SHALL be RESET_STATE and IR, src_sel, dst_sel, in_sel, alu_op, every strobe, halted and fault SHALL all be 0, asynchronously.
REQ-031 A reset mid-access SHALL drop mem_rd/mem_wr immediately, with no completion.
REQ-032 The first FETCH_A SHALL occur on the first clk edge after rst rises.

Structure
REQ-033 The opcode, in_sel and state encodings SHALL live in a shared package, tiny16_pkg.
REQ-034 The block SHALL contain one sub-module, instr_decode: combinational IR to {op-class, legal, selects}.

Verification
REQ-035 After reset, with mem_rdata = 16'h2A55 (LDI r5, 0x55) and mem_ready tied to 1, the bench SHALL see in_en pulse once with dst_sel = 5, in_sel = 1 and imm = 16'h0055, 5 cycles after rst release.
REQ-036 For ADD 16'h3680 (r3 <= r3 + r2), the bench SHALL see dst_sel = 3, src_sel = 2, alu_op = 0 and in_en for exactly one cycle.
REQ-037 For ST 16'h6440 with mem_ready low for 3 cycles, the bench SHALL see mem_wr, out_en and addr_sel = 1 held for 4 cycles and then dropped, with no in_en.
REQ-038 For JMP 16'h7080, the bench SHALL see in_en with dst_sel = 0 and in_sel = 3 and no pc_inc in that cycle; the next fetch drives src_sel = 0.
REQ-039 For op 16'h8000, the bench SHALL see fault = 1 and no further strobes. For 16'hF000, it SHALL see halted = 1 and no further strobes.
REQ-040 Asserting rst low during FETCH_B with mem_rd = 1 SHALL clear all outputs without a clock edge; the sequencer SHALL restart in FETCH_A.
